// File: rtl/light_lamp_driver.sv
// rtl/light_lamp_driver.sv - traffic-light lamp driver with stability filter, legality check and fault flash
module light_lamp_driver #(
    parameter int STABLE     = 1,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             clear_fault,
    output logic             lamp_r,
    output logic             lamp_g,
    output logic             lamp_y,
    output logic             fault,
    output logic             change,
    output logic [CNT_W-1:0] dwell
);

    localparam int SW = $clog2(STABLE + 1);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [SW-1:0] STABLE_C   = SW'(STABLE);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    localparam logic [2:0] C_RED = 3'd0;
    localparam logic [2:0] C_GRN = 3'd1;
    localparam logic [2:0] C_YEL = 3'd2;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state, state_n;
    logic [2:0]       acc, acc_n;
    logic [2:0]       cand, cand_n;
    logic [SW-1:0]    cnt, cnt_n;
    logic [FW-1:0]    flash_cnt, flash_cnt_n;
    logic             lamp_r_n, lamp_g_n, lamp_y_n, fault_n, change_n;
    logic [CNT_W-1:0] dwell_n, dwell_inc;
    logic             qual, code_valid;
    logic [2:0]       succ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            acc       <= C_RED;
            cand      <= C_RED;
            cnt       <= '0;
            flash_cnt <= '0;
            lamp_r    <= 1'b1;
            lamp_g    <= 1'b0;
            lamp_y    <= 1'b0;
            fault     <= 1'b0;
            change    <= 1'b0;
            dwell     <= '0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            flash_cnt <= flash_cnt_n;
            lamp_r    <= lamp_r_n;
            lamp_g    <= lamp_g_n;
            lamp_y    <= lamp_y_n;
            fault     <= fault_n;
            change    <= change_n;
            dwell     <= dwell_n;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cand_n      = cand;
        cnt_n       = cnt;
        flash_cnt_n = flash_cnt;
        lamp_r_n    = lamp_r;
        lamp_g_n    = lamp_g;
        lamp_y_n    = lamp_y;
        fault_n     = fault;
        change_n    = 1'b0;
        dwell_n     = dwell;

        // Stability filter runs every edge; the qualified code is cand_n.
        if (light == cand) begin
            cnt_n = (cnt == STABLE_C) ? cnt : cnt + SW'(1);
        end else begin
            cand_n = light;
            cnt_n  = SW'(1);
        end
        qual       = (cnt_n == STABLE_C) && (cand_n != acc);
        code_valid = (cand_n <= C_YEL);
        dwell_inc  = (&dwell) ? dwell : dwell + CNT_W'(1);

        case (acc)
            C_RED:   succ = C_GRN;
            C_GRN:   succ = C_YEL;
            default: succ = C_RED;
        endcase

        case (state)
            S_INIT, S_RUN: begin
                dwell_n = dwell_inc;
                if (qual) begin
                    if ((state == S_INIT) ? code_valid : (cand_n == succ)) begin
                        state_n  = S_RUN;
                        acc_n    = cand_n;
                        lamp_r_n = (cand_n == C_RED);
                        lamp_g_n = (cand_n == C_GRN);
                        lamp_y_n = (cand_n == C_YEL);
                        change_n = 1'b1;
                        dwell_n  = '0;
                    end else begin
                        state_n     = S_FAULT;
                        lamp_r_n    = 1'b0;
                        lamp_g_n    = 1'b0;
                        lamp_y_n    = 1'b1;
                        fault_n     = 1'b1;
                        dwell_n     = '0;
                        flash_cnt_n = '0;
                    end
                end
            end
            S_FAULT: begin
                dwell_n = '0;
                if (clear_fault) begin
                    // Full return to reset values, filter included; any code this edge is dropped.
                    state_n     = S_INIT;
                    acc_n       = C_RED;
                    cand_n      = C_RED;
                    cnt_n       = '0;
                    flash_cnt_n = '0;
                    lamp_r_n    = 1'b1;
                    lamp_g_n    = 1'b0;
                    lamp_y_n    = 1'b0;
                    fault_n     = 1'b0;
                end else if (flash_cnt == FLASH_LAST) begin
                    flash_cnt_n = '0;
                    lamp_y_n    = ~lamp_y;
                end else begin
                    flash_cnt_n = flash_cnt + FW'(1);
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_light_lamp_driver.sv
// tb/tb_light_lamp_driver.sv - scoreboard bench for light_lamp_driver
module tb_light_lamp_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] light1, light2;
    logic       clear1, clear2;
    logic       lamp_r1, lamp_g1, lamp_y1, fault1, change1;
    logic       lamp_r2, lamp_g2, lamp_y2, fault2, change2;
    logic [3:0] dwell1;
    logic [7:0] dwell2;

    int checks = 0;
    int errors = 0;

    logic [12:0] q1[$];
    logic [12:0] q2[$];

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LG = 3'b010;
    localparam logic [2:0] LY = 3'b001;
    localparam logic [2:0] LO = 3'b000;

    always #5 clock = ~clock;

    light_lamp_driver #(.STABLE(1), .FLASH_HALF(4), .CNT_W(4)) u1 (
        .clock(clock), .reset(reset), .light(light1), .clear_fault(clear1),
        .lamp_r(lamp_r1), .lamp_g(lamp_g1), .lamp_y(lamp_y1),
        .fault(fault1), .change(change1), .dwell(dwell1)
    );

    light_lamp_driver #(.STABLE(2), .FLASH_HALF(4), .CNT_W(8)) u2 (
        .clock(clock), .reset(reset), .light(light2), .clear_fault(clear2),
        .lamp_r(lamp_r2), .lamp_g(lamp_g2), .lamp_y(lamp_y2),
        .fault(fault2), .change(change2), .dwell(dwell2)
    );

    function automatic logic [12:0] ex(input logic [2:0] lmp, input logic f, input logic c, input int d);
        logic [7:0] d8;
        d8 = 8'(d);
        return {lmp, f, c, d8};
    endfunction

    function automatic logic [12:0] pack1();
        return {lamp_r1, lamp_g1, lamp_y1, fault1, change1, 4'b0000, dwell1};
    endfunction

    function automatic logic [12:0] pack2();
        return {lamp_r2, lamp_g2, lamp_y2, fault2, change2, dwell2};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got rgy=%b f=%b c=%b dwell=%0d want rgy=%b f=%b c=%b dwell=%0d",
                     name, got[12:10], got[9], got[8], got[7:0],
                     want[12:10], want[9], want[8], want[7:0]);
        end
    endtask

    // Monitor: one output sample per cycle, compared against whatever the driver queued.
    always begin
        @(posedge clock);
        #2;
        if (q1.size() > 0) check("u1", pack1(), q1.pop_front());
        if (q2.size() > 0) check("u2", pack2(), q2.pop_front());
    end

    task automatic step1(input logic [2:0] l, input logic c, input logic [12:0] e);
        @(negedge clock);
        light1 = l;
        clear1 = c;
        q1.push_back(e);
        @(posedge clock);
    endtask

    task automatic step2(input logic [2:0] l, input logic c, input logic [12:0] e);
        @(negedge clock);
        light2 = l;
        clear2 = c;
        q2.push_back(e);
        @(posedge clock);
    endtask

    initial begin
        reset  = 1'b1;
        light1 = 3'd0;
        light2 = 3'd0;
        clear1 = 1'b0;
        clear2 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_u1", pack1(), ex(LR, 0, 0, 0));
        check("reset_u2", pack2(), ex(LR, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;

        // STABLE=2: short glitches dropped, two samples needed
        step2(3'd1, 0, ex(LR, 0, 0, 2));
        step2(3'd0, 0, ex(LR, 0, 0, 3));
        step2(3'd0, 0, ex(LR, 0, 0, 4));
        step2(3'd1, 0, ex(LR, 0, 0, 5));
        step2(3'd1, 0, ex(LG, 0, 1, 0));
        step2(3'd1, 0, ex(LG, 0, 0, 1));
        step2(3'd7, 0, ex(LG, 0, 0, 2));
        step2(3'd1, 0, ex(LG, 0, 0, 3));
        step2(3'd1, 0, ex(LG, 0, 0, 4));
        step2(3'd0, 0, ex(LG, 0, 0, 5));
        step2(3'd0, 0, ex(LY, 1, 0, 0));
        step2(3'd2, 1, ex(LR, 0, 0, 0));
        step2(3'd2, 0, ex(LR, 0, 0, 1));
        step2(3'd2, 0, ex(LY, 0, 1, 0));

        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // STABLE=1: full cycle
        step1(3'd0, 0, ex(LR, 0, 0, 2));
        step1(3'd1, 0, ex(LG, 0, 1, 0));
        step1(3'd2, 0, ex(LY, 0, 1, 0));
        step1(3'd0, 0, ex(LR, 0, 1, 0));
        step1(3'd0, 0, ex(LR, 0, 0, 1));
        // Out-of-order YELLOW: fault flash 1111 0000 1111
        step1(3'd2, 0, ex(LY, 1, 0, 0));
        for (int i = 1; i < 12; i++)
            step1(3'd2, 0, ex(((i / 4) % 2 == 0) ? LY : LO, 1, 0, 0));
        step1(3'd2, 1, ex(LR, 0, 0, 0));
        step1(3'd2, 0, ex(LY, 0, 1, 0));
        // Invalid code
        step1(3'd7, 0, ex(LY, 1, 0, 0));
        step1(3'd7, 0, ex(LY, 1, 0, 0));
        step1(3'd7, 1, ex(LR, 0, 0, 0));
        step1(3'd0, 0, ex(LR, 0, 0, 1));
        // Dwell saturation at 15
        step1(3'd1, 0, ex(LG, 0, 1, 0));
        for (int i = 1; i <= 20; i++)
            step1(3'd1, 0, ex(LG, 0, 0, (i > 15) ? 15 : i));
        step1(3'd2, 0, ex(LY, 0, 1, 0));
        step1(3'd2, 1, ex(LY, 0, 0, 1));
        step1(3'd2, 0, ex(LY, 0, 0, 2));
        // Async reset mid-fault
        step1(3'd1, 0, ex(LY, 1, 0, 0));
        step1(3'd1, 0, ex(LY, 1, 0, 0));
        #3 reset = 1'b0;
        #1 check("async_reset_u1", pack1(), ex(LR, 0, 0, 0));
        @(negedge clock);
        reset  = 1'b1;
        light1 = 3'd1;
        q1.push_back(ex(LG, 0, 1, 0));
        @(posedge clock);
        step1(3'd2, 0, ex(LY, 0, 1, 0));

        repeat (2) @(posedge clock);
        #3;
        checks++;
        if (q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
